// File: rtl/eviction_policy_pkg.sv
// Shared types and one-hot helpers for the PLRU eviction engine.
package eviction_policy_pkg;

  localparam int unsigned MAX_WAYS = 64;

  typedef enum logic [1:0] {EP_IDLE, EP_SEARCH, EP_READY} ep_state_t;

  function automatic logic is_onehot(input logic [MAX_WAYS-1:0] v);
    return (v != '0) && ((v & (v - MAX_WAYS'(1))) == '0);
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAX_WAYS-1:0] v);
    int unsigned idx = 0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU update (two touches, allocate wins) and victim pick.
module plru_tree #(
  parameter  int unsigned NUM_WAYS  = 8,
  localparam int unsigned TREE_BITS = NUM_WAYS - 1,
  localparam int unsigned IDX_W     = $clog2(NUM_WAYS)
) (
  input  logic [TREE_BITS-1:0] plru_bits,
  input  logic [IDX_W-1:0]     hit_idx,
  input  logic                 hit_en,
  input  logic [IDX_W-1:0]     alloc_idx,
  input  logic                 alloc_en,
  input  logic [NUM_WAYS-1:0]  valid_vec,
  output logic [TREE_BITS-1:0] next_plru_bits,
  output logic [NUM_WAYS-1:0]  victim
);

  int unsigned hit_node;
  int unsigned alloc_node;
  int unsigned walk_node;
  int unsigned first_inv;
  logic        any_inv;

  // Heap-ordered path walk; each node on the path points away from the touched way.
  always_comb begin
    next_plru_bits = plru_bits;
    hit_node       = 0;
    alloc_node     = 0;
    for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
      if (hit_en) next_plru_bits[hit_node] = ~hit_idx[IDX_W-1-lvl];
      hit_node = 2 * hit_node + 1 + 32'(hit_idx[IDX_W-1-lvl]);
    end
    // Allocate is applied second so it overwrites shared path nodes.
    for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
      if (alloc_en) next_plru_bits[alloc_node] = ~alloc_idx[IDX_W-1-lvl];
      alloc_node = 2 * alloc_node + 1 + 32'(alloc_idx[IDX_W-1-lvl]);
    end
  end

  // Lowest invalid way wins; otherwise follow node bits from the root.
  always_comb begin
    victim    = '0;
    first_inv = 0;
    any_inv   = 1'b0;
    walk_node = 0;
    for (int unsigned w = NUM_WAYS; w > 0; w--) begin
      if (!valid_vec[w-1]) begin
        first_inv = w - 1;
        any_inv   = 1'b1;
      end
    end
    for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
      walk_node = 2 * walk_node + 1 + 32'(plru_bits[walk_node]);
    end
    if (any_inv) victim[first_inv] = 1'b1;
    else         victim[walk_node - TREE_BITS] = 1'b1;
  end

endmodule

// File: rtl/plru_eviction_policy.sv
// Tree pseudo-LRU eviction engine for one cache set (slave side of the policy interface).
module plru_eviction_policy
  import eviction_policy_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_WAYS-1:0] hitWay,
  input  logic                hit,
  input  logic [NUM_WAYS-1:0] missWay,
  input  logic                miss,
  input  logic [NUM_WAYS-1:0] allocateWay,
  input  logic                allocate,
  output logic [NUM_WAYS-1:0] evictionTarget,
  output logic                evictionReady
);

  localparam int unsigned TREE_BITS = NUM_WAYS - 1;
  localparam int unsigned IDX_W     = $clog2(NUM_WAYS);

  if (NUM_WAYS < 2 || NUM_WAYS > MAX_WAYS || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
    $error("NUM_WAYS must be a power of two between 2 and 64");
  end

  ep_state_t             state, state_next;
  logic [NUM_WAYS-1:0]   valid_vec;
  logic [TREE_BITS-1:0]  plru_bits, next_plru_bits;
  logic [NUM_WAYS-1:0]   target_reg, victim;
  logic [NUM_WAYS-1:0]   target_out, target_out_next;
  logic                  ready_out, ready_out_next;
  logic                  hit_ok, alloc_ok;
  logic [IDX_W-1:0]      hit_idx, alloc_idx;
  logic                  unused_miss_way;

  assign unused_miss_way = ^missWay;

  assign hit_ok    = hit && is_onehot(MAX_WAYS'(hitWay));
  assign alloc_ok  = allocate && is_onehot(MAX_WAYS'(allocateWay));
  assign hit_idx   = IDX_W'(onehot_to_idx(MAX_WAYS'(hitWay)));
  assign alloc_idx = IDX_W'(onehot_to_idx(MAX_WAYS'(allocateWay)));

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_tree (
    .plru_bits      (plru_bits),
    .hit_idx        (hit_idx),
    .hit_en         (hit_ok),
    .alloc_idx      (alloc_idx),
    .alloc_en       (alloc_ok),
    .valid_vec      (valid_vec),
    .next_plru_bits (next_plru_bits),
    .victim         (victim)
  );

  // Next-state and output-register inputs; allocate aborts any pending search/result.
  always_comb begin
    state_next      = state;
    ready_out_next  = 1'b0;
    target_out_next = '0;
    case (state)
      EP_IDLE:   if (miss) state_next = EP_SEARCH;
      EP_SEARCH: state_next = alloc_ok ? EP_IDLE : EP_READY;
      EP_READY: begin
        if (alloc_ok) begin
          state_next = EP_IDLE;
        end else begin
          ready_out_next  = 1'b1;
          target_out_next = target_reg;
        end
      end
      default:   state_next = EP_IDLE;
    endcase
  end

  // State, PLRU tree, valid bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EP_IDLE;
      valid_vec  <= '0;
      plru_bits  <= '0;
      target_reg <= '0;
      target_out <= '0;
      ready_out  <= 1'b0;
    end else begin
      state      <= state_next;
      plru_bits  <= next_plru_bits;
      target_out <= target_out_next;
      ready_out  <= ready_out_next;
      if (state == EP_SEARCH) target_reg <= victim;
      if (alloc_ok) valid_vec <= valid_vec | allocateWay;
    end
  end

  // Flag malformed hit vectors in simulation; the hit itself is dropped.
  always_ff @(posedge clk) begin
    if (!rst && hit) begin
      assert (hit_ok) else $warning("hitWay is not one-hot; hit ignored");
    end
  end

  assign evictionTarget = target_out;
  assign evictionReady  = ready_out;

endmodule

// File: tb/tb_plru_eviction_policy.sv
// Self-checking bench for plru_eviction_policy with a range-halving PLRU reference model.
module tb_plru_eviction_policy;

  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] hitWay, missWay, allocateWay, evictionTarget;
  logic          hit, miss, allocate, evictionReady;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit            m_valid [NW];
  bit            m_bits  [NW-1];
  int            m_phase;           // 0 idle, 1 searching, 2 result pending/held
  logic [NW-1:0] m_tgt;
  logic [NW-1:0] m_target;
  logic          m_ready;

  always #5 clk = ~clk;

  plru_eviction_policy #(.NUM_WAYS(NW)) dut (
    .clk            (clk),
    .rst            (rst),
    .hitWay         (hitWay),
    .hit            (hit),
    .missWay        (missWay),
    .miss           (miss),
    .allocateWay    (allocateWay),
    .allocate       (allocate),
    .evictionTarget (evictionTarget),
    .evictionReady  (evictionReady)
  );

  function automatic int model_victim();
    int node, lo, size;
    for (int w = 0; w < NW; w++) if (!m_valid[w]) return w;
    node = 0; lo = 0; size = NW;
    while (size > 1) begin
      size = size / 2;
      if (m_bits[node]) begin lo += size; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction

  task automatic model_touch(input int w);
    int node, lo, size, half;
    node = 0; lo = 0; size = NW;
    while (size > 1) begin
      half = size / 2;
      if (w >= lo + half) begin m_bits[node] = 0; node = 2 * node + 2; lo += half; end
      else begin m_bits[node] = 1; node = 2 * node + 1; end
      size = half;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) m_valid[i] = 0;
    for (int i = 0; i < NW - 1; i++) m_bits[i] = 0;
    m_phase = 0; m_tgt = '0; m_target = '0; m_ready = 0;
  endtask

  task automatic model_edge(input logic h, input logic [NW-1:0] hw, input logic m,
                            input logic a, input logic [NW-1:0] aw);
    int  v;
    bit  h_ok, a_ok;
    v    = model_victim();
    h_ok = h && ($countones(hw) == 1);
    a_ok = a && ($countones(aw) == 1);
    m_ready  = (m_phase == 2) && !a_ok;
    m_target = m_ready ? m_tgt : '0;
    case (m_phase)
      0:       m_phase = m ? 1 : 0;
      1:       begin m_phase = a_ok ? 0 : 2; m_tgt = NW'(1) << v; end
      default: m_phase = a_ok ? 0 : 2;
    endcase
    if (h_ok) model_touch($clog2(hw));
    if (a_ok) begin model_touch($clog2(aw)); m_valid[$clog2(aw)] = 1; end
  endtask

  task automatic step(input logic h, input logic [NW-1:0] hw, input logic m,
                      input logic a, input logic [NW-1:0] aw);
    hit = h; hitWay = hw; miss = m; allocate = a; allocateWay = aw;
    missWay = NW'($urandom());
    @(posedge clk);
    model_edge(h, hw, m, a, aw);
    #1;
    hit = 0; hitWay = '0; miss = 0; allocate = 0; allocateWay = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
  endtask

  // miss + two idle cycles: result visible after the third step
  task automatic request();
    step(0, '0, 1, 0, '0);
    step(0, '0, 0, 0, '0);
    step(0, '0, 0, 0, '0);
  endtask

  // fill all ways in victim order from reset; ends idle with way7 the last touch
  task automatic fill_all();
    do_reset();
    for (int i = 0; i < NW; i++) begin
      request();
      step(0, '0, 0, 1, m_target);
    end
  endtask

  task automatic test_reset();
    hit = 0; hitWay = '0; miss = 0; allocate = 0; allocateWay = '0; missWay = '0;
    do_reset();
    checks++;
    if (evictionReady !== 1'b0 || evictionTarget !== '0) begin
      failures++;
      $display("FAIL reset: ready=%b target=%h expected ready=0 target=00", evictionReady, evictionTarget);
    end
  endtask

  task automatic test_first_miss();
    do_reset();
    step(0, '0, 1, 0, '0);
    step(0, '0, 0, 0, '0);
    checks++;
    if (evictionReady !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: ready=%b expected 0 after edge 1", evictionReady);
    end
    step(0, '0, 0, 0, '0);
    checks++;
    if (evictionReady !== 1'b1 || evictionTarget !== 8'h01) begin
      failures++;
      $display("FAIL first_miss: ready=%b target=%h expected ready=1 target=01", evictionReady, evictionTarget);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, '0, (i == 2), 0, '0);
      checks++;
      if (evictionReady !== 1'b1 || evictionTarget !== 8'h01) begin
        failures++;
        $display("FAIL hold_%0d: ready=%b target=%h expected ready=1 target=01", i, evictionReady, evictionTarget);
      end
    end
    step(0, '0, 0, 1, 8'h01);
    checks++;
    if (evictionReady !== 1'b0 || evictionTarget !== '0) begin
      failures++;
      $display("FAIL alloc_clear: ready=%b target=%h expected ready=0 target=00", evictionReady, evictionTarget);
    end
  endtask

  task automatic test_invalid_first();
    logic [NW-1:0] exp_t;
    do_reset();
    for (int i = 0; i < NW; i++) begin
      request();
      exp_t = NW'(1) << i;
      checks++;
      if (evictionReady !== 1'b1 || evictionTarget !== exp_t) begin
        failures++;
        $display("FAIL invalid_first_%0d: ready=%b target=%h expected ready=1 target=%h", i, evictionReady, evictionTarget, exp_t);
      end
      step(0, '0, 0, 1, exp_t);
      checks++;
      if (evictionReady !== 1'b0) begin
        failures++;
        $display("FAIL invalid_first_drop_%0d: ready=%b expected 0", i, evictionReady);
      end
    end
  endtask

  task automatic test_plru_walk();
    fill_all();
    request();
    checks++;
    if (evictionTarget !== 8'h01 || evictionReady !== 1'b1) begin
      failures++;
      $display("FAIL walk_all_valid: target=%h expected 01", evictionTarget);
    end
    step(1, 8'h01, 0, 0, '0);
    step(0, '0, 0, 1, 8'h01);
    request();
    checks++;
    if (evictionTarget !== 8'h10 || evictionReady !== 1'b1) begin
      failures++;
      $display("FAIL walk_after_touch0: target=%h expected 10", evictionTarget);
    end
  endtask

  task automatic test_alloc_other();
    do_reset();
    request();
    step(0, '0, 0, 1, 8'h04);
    checks++;
    if (evictionReady !== 1'b0 || evictionTarget !== '0) begin
      failures++;
      $display("FAIL alloc_other_clear: ready=%b target=%h expected ready=0 target=00", evictionReady, evictionTarget);
    end
    step(0, '0, 0, 1, 8'h01);
    step(0, '0, 0, 1, 8'h02);
    request();
    checks++;
    if (evictionTarget !== 8'h08 || evictionTarget !== m_target) begin
      failures++;
      $display("FAIL alloc_other_valid: target=%h expected 08 (model %h)", evictionTarget, m_target);
    end
  endtask

  task automatic test_reset_in_ready();
    fill_all();
    request();
    do_reset();
    checks++;
    if (evictionReady !== 1'b0 || evictionTarget !== '0) begin
      failures++;
      $display("FAIL reset_in_ready: ready=%b target=%h expected ready=0 target=00", evictionReady, evictionTarget);
    end
    request();
    checks++;
    if (evictionReady !== 1'b1 || evictionTarget !== 8'h01) begin
      failures++;
      $display("FAIL reset_clears_valid: target=%h expected 01", evictionTarget);
    end
  endtask

  task automatic test_same_cycle();
    fill_all();
    step(1, 8'h02, 0, 1, 8'h01);
    step(1, 8'h03, 0, 0, '0);
    request();
    checks++;
    if (evictionReady !== 1'b1 || evictionTarget !== 8'h10) begin
      failures++;
      $display("FAIL alloc_priority: target=%h expected 10", evictionTarget);
    end
  endtask

  task automatic test_miss_hit_same_cycle();
    fill_all();
    step(1, 8'h01, 1, 0, '0);
    step(0, '0, 0, 0, '0);
    step(0, '0, 0, 0, '0);
    checks++;
    if (evictionTarget !== m_target || evictionReady !== m_ready) begin
      failures++;
      $display("FAIL miss_hit: target=%h ready=%b expected target=%h ready=%b", evictionTarget, evictionReady, m_target, m_ready);
    end
  endtask

  task automatic test_random();
    logic          h, m, a;
    logic [NW-1:0] hw, aw;
    fill_all();
    for (int i = 0; i < 400; i++) begin
      h  = ($urandom_range(0, 2) == 0);
      m  = ($urandom_range(0, 3) == 0);
      a  = (m_phase == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      hw = NW'(1) << $urandom_range(0, NW - 1);
      aw = (m_phase == 2 && $urandom_range(0, 1) == 1) ? m_tgt : NW'(1) << $urandom_range(0, NW - 1);
      if (i == 200) do_reset();
      step(h, hw, m, a, aw);
      checks++;
      if (evictionReady !== m_ready || evictionTarget !== m_target) begin
        failures++;
        $display("FAIL random_%0d: ready=%b target=%h expected ready=%b target=%h", i, evictionReady, evictionTarget, m_ready, m_target);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_invalid_first();
    test_plru_walk();
    test_alloc_other();
    test_reset_in_ready();
    test_same_cycle();
    test_miss_hit_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
